// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment display blocks.
//   SEG_OFF / SEG_DASH : active-low segment patterns (gfedcba order, bit 6 = g).
//   hex_to_seg()       : active-low hex digit (0-F) to segment pattern.
//   clog2()            : ceiling log2 usable in parameter expressions.
//   max1()             : clamps a derived width to at least one bit.
package seg_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned x;
        r = 0;
        x = 1;
        while (x < longint'(v)) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max1(input int unsigned v);
        return (v > 1) ? v : 1;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] pat;
        pat = SEG_OFF;
        unique case (h)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..PRESCALE-1 counter with an enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset (counter to 0)
//   en    : count enable; low freezes the counter and suppresses tick
//   tick  : high for one cycle when the counter is at PRESCALE-1 and en is high
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    localparam int unsigned PS_W = max1(clog2(PRESCALE))
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            at_top;

    assign at_top = (ps_cnt_q == PS_W'(PRESCALE - 1));
    assign tick   = en & at_top;

    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (en) begin
            ps_cnt_d = at_top ? '0 : ps_cnt_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with per-digit source select.
//   clk, rst_n : clock, asynchronous active-low reset
//   src        : NUM_SRC active-low 7-bit patterns, source k at src[7k+6:7k]
//   sel        : per-digit source select, digit d at sel[SEL_W*d +: SEL_W]
//   dp_in      : per-digit active-low decimal point
//   en         : scan enable; low blanks outputs and freezes the scan
//   seg, dp    : registered active-low segment / decimal-point drive
//   an         : registered active-low one-hot anode drive
//   digit_idx  : registered index of the digit being scanned
// Build option: define SEG_SCAN_DEADTIME_EN to insert one blank cycle after
// every scan advance (anti-ghosting); each digit is then lit PRESCALE-1 cycles.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned PRESCALE    = 100000,
    parameter logic [6:0]  DEFAULT_PAT = SEG_DASH,
    localparam int unsigned SEL_W = max1(clog2(NUM_SRC + 1)),
    localparam int unsigned IDX_W = max1(clog2(NUM_DIGITS))
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*7-1:0]        src,
    input  logic [NUM_DIGITS*SEL_W-1:0] sel,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        en,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [IDX_W-1:0]            digit_idx
);

    logic                  tick;
    logic                  blank;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [SEL_W-1:0]      cur_sel;
    logic [6:0]            cur_seg;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] cur_an;

    scan_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    // Explicit wrap so non-power-of-two digit counts never reach an unused index.
    always_comb begin
        digit_idx_d = digit_idx_q;
        if (tick) begin
            digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                 : digit_idx_q + IDX_W'(1);
        end
    end

    // Selection uses the pre-advance index, so the registered outputs trail
    // digit_idx by one cycle and every digit is shown for a full PRESCALE slot.
    always_comb begin
        cur_sel = '0;
        cur_dp  = 1'b1;
        cur_an  = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx_q == IDX_W'(d)) begin
                cur_sel   = sel[SEL_W*d +: SEL_W];
                cur_dp    = dp_in[d];
                cur_an[d] = 1'b0;
            end
        end
        cur_seg = DEFAULT_PAT;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                cur_seg = src[7*k +: 7];
            end
        end
    end

    always_comb begin
`ifdef SEG_SCAN_DEADTIME_EN
        // Blank the slot boundary: the cycle after a tick shows nothing.
        blank = ~en | tick;
`else
        blank = ~en;
`endif
        seg_d = blank ? SEG_OFF : cur_seg;
        dp_d  = blank ? 1'b1    : cur_dp;
        an_d  = blank ? '1      : cur_an;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_idx_q <= '0;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux (4 digits, 3 sources, PRESCALE 4).
// Stimulus pushes the expected {an, seg, dp, digit_idx} for the coming edge;
// a negedge monitor pops and compares entries tagged for the current cycle.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [20:0] src;
    logic [7:0]  sel;
    logic [3:0]  dp_in;
    logic        en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    seg_scan_mux #(
        .NUM_DIGITS (4),
        .NUM_SRC    (3),
        .PRESCALE   (4),
        .DEFAULT_PAT(7'b0111111)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src      (src),
        .sel      (sel),
        .dp_in    (dp_in),
        .en       (en),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [13:0] exp;
        int          ph;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   phase = 0;
    int   cur_d = 0;
    int   cur_c = 0;

    // Hand-set expectation tables, indexed by digit.
    logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_tab [4] = '{7'h40, 7'h24, 7'h79, 7'h3F};
    logic       dp_tab  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cyc %0d: an/seg/dp/idx got %h_%h_%b_%0d want %h_%h_%b_%0d",
                     name, cyc, got[13:10], got[9:3], got[2], got[1:0],
                     want[13:10], want[9:3], want[2], want[1:0]);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL stale_entry phase%0d: tagged cyc %0d, now %0d", e.ph, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check($sformatf("phase%0d", e.ph), {an, seg, dp, digit_idx}, e.exp);
            n_cmp = n_cmp + 1;
            if (!(an == 4'hF || $onehot(~an))) begin
                n_bad = n_bad + 1;
                $display("FAIL an_onehot phase%0d: an got %b want one-hot-low or 1111",
                         e.ph, an);
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                        input logic [1:0] i);
        exp_t x;
        x.cyc = cyc + 1;
        x.exp = {a, s, d, i};
        x.ph  = phase;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        int  nd;
        logic blank;
        for (int i = 0; i < n; i++) begin
            nd    = (cur_c == 3) ? (cur_d + 1) % 4 : cur_d;
            blank = 1'b0;
`ifdef SEG_SCAN_DEADTIME_EN
            blank = (cur_c == 3);
`endif
            if (blank) push(4'hF, 7'h7F, 1'b1, 2'(nd));
            else       push(an_tab[cur_d], seg_tab[cur_d], dp_tab[cur_d], 2'(nd));
            step();
            cur_c = (cur_c + 1) % 4;
            cur_d = nd;
        end
    endtask

    initial begin
        src   = {7'h79, 7'h24, 7'h40};
        sel   = {2'd3, 2'd2, 2'd1, 2'd0};
        dp_in = 4'hF;
        en    = 1'b1;
        rst_n = 1'b0;

        // Reset hold.
        phase = 0;
        step();
        push(4'hF, 7'h7F, 1'b1, 2'd0);
        step();
        push(4'hF, 7'h7F, 1'b1, 2'd0);
        step();

        // Normal scan: five slots of four cycles each.
        phase = 1;
        rst_n = 1'b1;
        cur_d = 0;
        cur_c = 0;
        run(20);

        // Select change on the lit digit takes effect on the next edge.
        phase = 2;
        run(13);
        sel[1:0]   = 2'd2;
        seg_tab[0] = 7'h79;
        run(1);
        sel[1:0]   = 2'd0;
        seg_tab[0] = 7'h40;
        run(1);
        run(4);

        // Enable drops on digit 1's tick cycle; no advance, blank for 10 cycles.
        phase = 3;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(4'hF, 7'h7F, 1'b1, 2'(cur_d));
            step();
        end
        en = 1'b1;
        run(3);

        // Asynchronous reset mid-digit 2.
        phase = 4;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {an, seg, dp, digit_idx}, {4'hF, 7'h7F, 1'b1, 2'd0});
        push(4'hF, 7'h7F, 1'b1, 2'd0);
        step();
        rst_n = 1'b1;
        cur_d = 0;
        cur_c = 0;
        run(8);

        // Decimal point on digit 2 only.
        phase = 5;
        dp_in     = 4'b1011;
        dp_tab[2] = 1'b0;
        run(16);

        repeat (3) @(posedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
